// File: rtl/svn_pkg.sv
// rtl/svn_pkg.sv - shared constants for the seven-segment scan multiplexer
package svn_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        return SEG_HEX[v];
    endfunction

endpackage

// File: rtl/svn_scan_mux_if.sv
// rtl/svn_scan_mux_if.sv - update/display bundle between a host and the scan multiplexer
interface svn_scan_mux_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    upd;
    logic                    upd_ack;
    logic [6:0]              seg;
    logic                    DP;
    logic [NUM_DIGITS-1:0]   AN;
    logic                    frame;

    modport master (
        output digits, dp_in, blank, upd,
        input  upd_ack, seg, DP, AN, frame
    );

    modport slave (
        input  digits, dp_in, blank, upd,
        output upd_ack, seg, DP, AN, frame
    );
endinterface

// File: rtl/svn_dcdr.sv
// rtl/svn_dcdr.sv - combinational hex nibble to active-low segment decoder
module svn_dcdr
    import svn_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);
    assign seg_o = hex_to_seg(hex_i);
endmodule

// File: rtl/svn_scan_mux.sv
// rtl/svn_scan_mux.sv - double-buffered multiplexed seven-segment scanner
// Optional anode PWM dimming is compiled in with SVN_SCAN_DIM_EN.
module svn_scan_mux
    import svn_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000
) (
    input  logic clk,
    input  logic sys_rst,
`ifdef SVN_SCAN_DIM_EN
    input  logic [3:0] dim,
`endif
    svn_scan_mux_if.slave bus
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(MAX_DIGITS);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] digits;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
    } disp_t;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  pending_q, pending_d;
    disp_t                 hold_q, hold_d;
    disp_t                 shadow_q, shadow_d;
    logic                  upd_ack_q, upd_ack_d;
    logic                  frame_q, frame_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic       tick, xfer;
    disp_t      src;
    logic [3:0] nib;
    logic       dp_sel, blank_sel;
    logic [6:0] dec_seg;

    assign tick = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign xfer = tick && (idx_q == '0) && pending_q;
    // On the transfer tick slot 0 must already show the new data, so bypass the shadow
    assign src  = xfer ? hold_q : shadow_q;

    always_comb begin
        nib       = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib       = src.digits[4*k +: 4];
                dp_sel    = src.dp[k];
                blank_sel = src.blank[k];
            end
        end
    end

    svn_dcdr u_dcdr (
        .hex_i (nib),
        .seg_o (dec_seg)
    );

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        seg_d     = seg_q;
        dp_d      = dp_q;
        an_d      = an_q;
        hold_d    = hold_q;
        shadow_d  = xfer ? hold_q : shadow_q;
        pending_d = bus.upd | (pending_q & ~xfer);
        upd_ack_d = xfer;
        frame_d   = tick && (idx_q == '0);
        if (bus.upd) begin
            hold_d = '{digits: bus.digits, dp: bus.dp_in, blank: bus.blank};
        end
        if (tick) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            seg_d = blank_sel ? SEG_BLANK : dec_seg;
            dp_d  = blank_sel | ~dp_sel;
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            hold_q    <= '0;
            shadow_q  <= '0;
            upd_ack_q <= 1'b0;
            frame_q   <= 1'b0;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            an_q      <= '1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            hold_q    <= hold_d;
            shadow_q  <= shadow_d;
            upd_ack_q <= upd_ack_d;
            frame_q   <= frame_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

`ifdef SVN_SCAN_DIM_EN
    logic [3:0]            pwm_q, pwm_d;
    logic [NUM_DIGITS-1:0] an_pwm_q, an_pwm_d;

    always_comb begin
        pwm_d    = pwm_q + 4'd1;
        an_pwm_d = an_d | {NUM_DIGITS{pwm_q > dim}};
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            pwm_q    <= 4'd0;
            an_pwm_q <= '1;
        end else begin
            pwm_q    <= pwm_d;
            an_pwm_q <= an_pwm_d;
        end
    end

    assign bus.AN = an_pwm_q;
`else
    assign bus.AN = an_q;
`endif

    assign bus.seg     = seg_q;
    assign bus.DP      = dp_q;
    assign bus.upd_ack = upd_ack_q;
    assign bus.frame   = frame_q;
endmodule

// File: tb/tb_svn_scan_mux.sv
// tb/tb_svn_scan_mux.sv - self-checking bench for svn_scan_mux (NUM_DIGITS=4, SCAN_DIV=4)
module tb_svn_scan_mux;
    localparam int ND = 4;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 clk = ~clk;

`ifdef SVN_SCAN_DIM_EN
    logic [3:0] dim = 4'd15;
`endif

    svn_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

    svn_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
`ifdef SVN_SCAN_DIM_EN
        .dim     (dim),
`endif
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b1;
    bit mon_an = 1'b1;

    logic [6:0] hexseg [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model: edge count since reset plus a log of every captured update
    typedef struct {
        int         edge_no;
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  bl;
    } upd_t;

    int   n = 0;
    upd_t hist[$];

    always @(posedge clk) begin
        if (sys_rst) begin
            n = 0;
            hist.delete();
        end else begin
            n++;
            if (bus.upd) hist.push_back('{n, bus.digits, bus.dp_in, bus.blank});
        end
    end

    function automatic void model_expect(output logic [3:0] an, output logic [6:0] sg,
                                         output logic dp, output logic fr, output logic ack);
        int m, slot, f, ef, ep;
        logic [15:0] d;
        logic [3:0]  dpv, bl;
        logic        any;
        an = 4'hF; sg = 7'h7F; dp = 1'b1; fr = 1'b0; ack = 1'b0;
        if (n >= SD) begin
            m    = n / SD;
            slot = (m - 1) % ND;
            f    = (m - 1) / ND;
            ef   = (f * ND + 1) * SD;
            ep   = (f == 0) ? 1 : ((f - 1) * ND + 1) * SD;
            d = '0; dpv = '0; bl = '0; any = 1'b0;
            foreach (hist[i]) begin
                if (hist[i].edge_no < ef) begin
                    d = hist[i].d; dpv = hist[i].dp; bl = hist[i].bl;
                end
                if (hist[i].edge_no >= ep && hist[i].edge_no < ef) any = 1'b1;
            end
            an = 4'hF ^ (4'h1 << slot);
            if (bl[slot]) begin
                sg = 7'h7F;
                dp = 1'b1;
            end else begin
                sg = hexseg[(d >> (4 * slot)) & 16'hF];
                dp = ~dpv[slot];
            end
            fr  = (n == ef);
            ack = fr && any;
        end
    endfunction

    always @(negedge clk) begin
        logic [3:0] e_an; logic [6:0] e_sg; logic e_dp, e_fr, e_ack;
        if (mon_en) begin
            model_expect(e_an, e_sg, e_dp, e_fr, e_ack);
            checks++;
            if ((mon_an && bus.AN !== e_an) || bus.seg !== e_sg || bus.DP !== e_dp ||
                bus.frame !== e_fr || bus.upd_ack !== e_ack) begin
                failures++;
                $display("FAIL monitor n=%0d got AN=%h seg=%h DP=%b frame=%b ack=%b expected AN=%h seg=%h DP=%b frame=%b ack=%b",
                         n, bus.AN, bus.seg, bus.DP, bus.frame, bus.upd_ack, e_an, e_sg, e_dp, e_fr, e_ack);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.frame === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_upd(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        bus.digits = d; bus.dp_in = dp; bus.blank = bl; bus.upd = 1'b1;
        @(negedge clk);
        bus.upd = 1'b0;
    endtask

    typedef struct {
        logic [15:0]       d;
        logic [3:0]        dp;
        logic [3:0]        bl;
        logic [3:0][6:0]   seg;
        logic [3:0]        dpo;
    } vec_t;

    vec_t tbl[4];

    initial begin
        bit ok;
        int lows;
        bus.digits = '0; bus.dp_in = '0; bus.blank = '0; bus.upd = 1'b0;

        tbl[0] = '{16'h3A71, 4'b0010, 4'b0000, {7'h30, 7'h08, 7'h78, 7'h79}, 4'b1101};
        tbl[1] = '{16'h0000, 4'b0000, 4'b0100, {7'h40, 7'h7F, 7'h40, 7'h40}, 4'b1111};
        tbl[2] = '{16'hFEDC, 4'b1111, 4'b0000, {7'h0E, 7'h06, 7'h21, 7'h46}, 4'b0000};
        tbl[3] = '{16'h9865, 4'b0101, 4'b1000, {7'h7F, 7'h00, 7'h02, 7'h12}, 4'b1010};

        repeat (3) @(negedge clk);
        check("reset_an", 32'(bus.AN), 32'hF);
        check("reset_seg", 32'(bus.seg), 32'h7F);
        check("reset_dp", 32'(bus.DP), 32'h1);
        check("reset_pulses", 32'({bus.frame, bus.upd_ack}), 32'h0);
        sys_rst = 1'b0;

        repeat (3 * ND * SD) @(negedge clk);

        foreach (tbl[t]) begin
            wait_frame(ok);
            check("frame_timeout", 32'(ok), 32'h1);
            repeat (5) @(negedge clk);
            do_upd(tbl[t].d, tbl[t].dp, tbl[t].bl);
            wait_frame(ok);
            check("frame_timeout", 32'(ok), 32'h1);
            check("tbl_ack", 32'(bus.upd_ack), 32'h1);
            for (int s = 0; s < ND; s++) begin
                check("tbl_an", 32'(bus.AN), 32'(4'hF ^ (4'h1 << s)));
                check("tbl_seg", 32'(bus.seg), 32'(tbl[t].seg[s]));
                check("tbl_dp", 32'(bus.DP), 32'(tbl[t].dpo[s]));
                if (s != ND - 1) repeat (SD) @(negedge clk);
            end
        end

        wait_frame(ok);
        check("frame_timeout", 32'(ok), 32'h1);
        repeat (2) @(negedge clk);
        do_upd(16'h1111, 4'h0, 4'h0);
        repeat (3) @(negedge clk);
        do_upd(16'h2222, 4'h0, 4'h0);
        wait_frame(ok);
        check("last_wins_ack", 32'({ok, bus.upd_ack}), 32'h3);
        check("last_wins_seg", 32'(bus.seg), 32'h24);
        wait_frame(ok);
        check("last_wins_no_second_ack", 32'({ok, bus.upd_ack}), 32'h2);

        wait_frame(ok);
        check("frame_timeout", 32'(ok), 32'h1);
        repeat (3) @(negedge clk);
        do_upd(16'h5555, 4'h0, 4'h0);
        repeat (ND * SD - 1 - 4) @(negedge clk);
        do_upd(16'h6666, 4'h0, 4'h0);
        check("coincident_old_ack", 32'({bus.frame, bus.upd_ack}), 32'h3);
        check("coincident_old_seg", 32'(bus.seg), 32'h12);
        wait_frame(ok);
        check("coincident_new_ack", 32'({ok, bus.upd_ack}), 32'h3);
        check("coincident_new_seg", 32'(bus.seg), 32'h02);

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                sys_rst = 1'b1;
                repeat (2) @(negedge clk);
                sys_rst = 1'b0;
            end else if ($urandom_range(0, 11) == 0) begin
                do_upd(16'($urandom), 4'($urandom),
                       ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
            end else begin
                @(negedge clk);
            end
        end

        repeat (5) @(negedge clk);
        sys_rst = 1'b1;
        @(negedge clk);
        check("midrun_reset_an", 32'(bus.AN), 32'hF);
        check("midrun_reset_seg", 32'({bus.seg, bus.DP}), 32'hFF);
        sys_rst = 1'b0;
        repeat (2 * ND * SD) @(negedge clk);

`ifdef SVN_SCAN_DIM_EN
        mon_an = 1'b0;
        dim = 4'd3;
        repeat (4) @(negedge clk);
        lows = 0;
        for (int c = 0; c < 64; c++) begin
            if (bus.AN != 4'hF) lows++;
            @(negedge clk);
        end
        check("dim3_duty", 32'(lows), 32'd16);
        dim = 4'd15;
        repeat (2) @(negedge clk);
        lows = 0;
        for (int c = 0; c < 32; c++) begin
            if (bus.AN != 4'hF) lows++;
            @(negedge clk);
        end
        check("dim15_duty", 32'(lows), 32'd32);
        mon_an = 1'b1;
`endif

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached");
        $fatal(1);
    end
endmodule

// File: doc/svn_scan_mux.md
SVN_SCAN_MUX -- requirements
Module: svn_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 100000, clocks per digit slot (legal >= 2).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port sys_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port digits  input  4*NUM_DIGITS  hex nibble per digit, digit k at [4k+3:4k].
REQ-006 SHALL have port dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-007 SHALL have port blank  input  NUM_DIGITS  per-digit blanking, 1 = digit dark.
REQ-008 SHALL have port upd  input  1  one-cycle strobe capturing digits/dp_in/blank into holding register.
REQ-009 SHALL have port upd_ack  output  1  one-cycle pulse when holding data transfers to display shadow.
REQ-010 SHALL have port seg  output  7  segments {CG..CA}, active-low, registered.
REQ-011 SHALL have port DP  output  1  decimal point, active-low, registered.
REQ-012 SHALL have port AN  output  NUM_DIGITS  anode enables, active-low, one-cold, registered.
REQ-013 SHALL have port frame  output  1  one-cycle pulse on the tick that displays digit 0.

Function
REQ-014 Prescaler cnt SHALL count 0..SCAN_DIV-1 and wrap; tick asserted for the one cycle cnt==SCAN_DIV-1.
REQ-015 On tick, outputs SHALL present slot idx (AN[idx]=0, others 1); idx then advances, NUM_DIGITS-1 wraps to 0.
REQ-016 Latency: AN, seg, DP SHALL change in the same cycle (cycle after tick), never skewed.
REQ-017 seg SHALL be standard hex 0-F active-low encoding; blanked digit: seg=7'h7F, DP=1, AN still driven for the slot.
REQ-018 upd SHALL load holding register and set pending; a second upd before transfer SHALL overwrite holding (last wins).
REQ-019 On the tick displaying slot 0 with pending set, shadow SHALL load from holding, pending clears, upd_ack pulses, and slot 0 SHALL already show new data.
REQ-020 upd coincident with that transfer tick: the transfer SHALL use holding as it was before this cycle; new capture stays pending for next frame.
REQ-021 Shadow SHALL never change mid-frame; no tearing between digits.
REQ-022 NUM_DIGITS=1: idx fixed at 0, every tick is a frame tick.

Reset
REQ-023 While sys_rst=1 at a clock edge: cnt=0, idx=0, pending=0, holding=0, shadow=0, upd_ack=0, frame=0.
REQ-024 Reset values SHALL be AN all ones, seg=7'h7F, DP=1 (display dark) until the first tick.
REQ-025 Reset asserted mid-frame SHALL abort scan immediately; first post-reset tick shows digit 0.

Configuration
REQ-026 Macro SVN_SCAN_DIM_EN SHALL compile in input dim[3:0] and a free-running 4-bit pwm counter (reset 0).
REQ-027 With SVN_SCAN_DIM_EN, selected AN bit SHALL be 0 only while pwm <= dim; dim=15 gives full on, dim=0 gives 1/16 duty; seg/DP unaffected.
REQ-028 Without SVN_SCAN_DIM_EN, port dim SHALL not exist and the selected anode is on for the whole slot.

Structure
REQ-029 Package svn_pkg SHALL hold the hex-to-segment constant table, blank pattern 7'h7F and the MAX_DIGITS=8 constant.
REQ-030 Segment decode SHALL reuse one instance of existing combinational svn_dcdr; prescaler, scan index, buffering and PWM live in svn_scan_mux.

Verification (NUM_DIGITS=4, SCAN_DIV=4)
REQ-031 Reset release, no upd -> AN=4'hF, seg=7'h7F for 3 clocks; then AN sequence E,D,B,7,E every 4 clocks, seg=7'h40 ("0").
REQ-032 upd with digits=16'h3A71, dp_in=4'b0010 mid-frame -> unchanged until next frame; then slot 0 seg=7'h79 ("1"), slot 1 "7" with DP=0, slot 2 "A", slot 3 "3"; upd_ack and frame coincide once.
REQ-033 Two upd strobes (16'h1111 then 16'h2222) in one frame -> only 16'h2222 ever displayed, one upd_ack.
REQ-034 upd on the slot-0 tick cycle -> old holding transferred now, new value appears one frame later with second upd_ack.
REQ-035 blank=4'b0100 -> slot 2 AN=4'hB with seg=7'h7F, DP=1; other slots normal.
REQ-036 SVN_SCAN_DIM_EN, dim=3 -> selected anode low 4 of every 16 clocks; dim=15 -> low continuously; sys_rst mid-slot -> all dark next edge.
